// File: rtl/channel_grant_sequencer.sv
// Round-robin DMA channel grant sequencer.
// Each channel holds a remaining-beat counter. An IDLE/GRANT/RELEASE FSM
// hands out frame-limited grants, one channel at a time, and pulses
// ch_done when the final slice of a channel's transfer is released.
module channel_grant_sequencer #(
    parameter int C_NUM_CHANNELS           = 4,
    parameter int C_TRANSACTION_SIZE_WIDTH = 32,
    parameter int C_FRAME_SIZE             = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ch_start [C_NUM_CHANNELS],
    input  logic [C_TRANSACTION_SIZE_WIDTH-1:0] ch_size  [C_NUM_CHANNELS],
    input  logic                                beat_valid,
    output logic [C_NUM_CHANNELS-1:0]           grant,
    output logic                                grant_valid,
    output logic [$clog2(C_NUM_CHANNELS):0]     active_channel,
    output logic [$clog2(C_FRAME_SIZE):0]       grant_beats,
    output logic [C_NUM_CHANNELS-1:0]           ch_done,
    output logic                                transaction_completed
);

    localparam int N  = C_NUM_CHANNELS;
    localparam int IW = $clog2(C_NUM_CHANNELS);
    localparam int AW = IW + 1;
    localparam int FW = $clog2(C_FRAME_SIZE) + 1;
    localparam int TW = C_TRANSACTION_SIZE_WIDTH;
    localparam int CW = (TW > FW) ? TW : FW;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [TW-1:0]     remaining_r [N];
    logic [FW-1:0]     beat_cnt_r;
    logic [N-1:0]      grant_r;
    logic              grant_valid_r;
    logic [AW-1:0]     active_channel_r;
    logic [FW-1:0]     grant_beats_r;
    logic [N-1:0]      ch_done_r;
    logic              transaction_completed_r;

    logic [N-1:0]      pending_s;
    logic [N-1:0]      start_ok_s;
    logic [IW:0]       search_s;
    logic              winner_found_s;
    logic [IW-1:0]     winner_idx_s;
    logic [IW-1:0]     active_idx_s;
    logic [CW-1:0]     winner_rem_s;
    logic [FW-1:0]     winner_beats_s;
    logic [N-1:0]      winner_onehot_s;
    logic [N-1:0]      active_onehot_s;
    logic              last_beat_s;
    logic              done_hit_s;

    // First pending channel at or after (last + 1), wrapping; MSB = found.
    function automatic logic [IW:0] find_winner(input logic [N-1:0] pending,
                                                input logic [IW-1:0] last);
        logic          found;
        logic [IW-1:0] idx;
        int            cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(last) + k + 32'sd1;
            if (cand >= N) begin
                cand = cand - N;
            end else begin
                cand = cand;
            end
            if (!found && pending[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Per-channel pending flags and start qualification (owner starts dropped).
    always_comb begin
        pending_s  = '0;
        start_ok_s = '0;
        for (int i = 0; i < N; i++) begin
            pending_s[i]  = (remaining_r[i] != '0);
            start_ok_s[i] = ch_start[i]
                            && (remaining_r[i] == '0)
                            && (ch_size[i] != '0)
                            && !((state_r != ST_IDLE) && (active_idx_s == IW'(i)));
        end
    end

    // Winner search, slice sizing and release bookkeeping terms.
    always_comb begin
        active_idx_s    = active_channel_r[IW-1:0];
        search_s        = find_winner(pending_s, active_idx_s);
        winner_found_s  = search_s[IW];
        winner_idx_s    = search_s[IW-1:0];
        winner_rem_s    = CW'(remaining_r[winner_idx_s]);
        if (winner_rem_s > CW'(C_FRAME_SIZE)) begin
            winner_beats_s = FW'(C_FRAME_SIZE);
        end else begin
            winner_beats_s = FW'(winner_rem_s);
        end
        winner_onehot_s = {{(N-1){1'b0}}, 1'b1} << winner_idx_s;
        active_onehot_s = {{(N-1){1'b0}}, 1'b1} << active_idx_s;
        last_beat_s     = beat_valid && (beat_cnt_r == (grant_beats_r - FW'(1)));
        done_hit_s      = (CW'(remaining_r[active_idx_s]) == CW'(grant_beats_r));
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (winner_found_s) begin
                    state_next_s = ST_GRANT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (last_beat_s) begin
                    state_next_s = ST_RELEASE;
                end else begin
                    state_next_s = ST_GRANT;
                end
            end
            ST_RELEASE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Remaining-beat counters: slice subtraction on release, load on accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                remaining_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if ((state_r == ST_RELEASE) && (active_idx_s == IW'(i))) begin
                    remaining_r[i] <= remaining_r[i] - TW'(grant_beats_r);
                end else if (start_ok_s[i]) begin
                    remaining_r[i] <= ch_size[i];
                end else begin
                    remaining_r[i] <= remaining_r[i];
                end
            end
        end
    end

    // State register and registered grant/completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r                 <= ST_IDLE;
            beat_cnt_r              <= '0;
            grant_r                 <= '0;
            grant_valid_r           <= 1'b0;
            grant_beats_r           <= '0;
            ch_done_r               <= '0;
            transaction_completed_r <= 1'b0;
            active_channel_r        <= AW'(C_NUM_CHANNELS - 1);
        end else begin
            state_r                 <= state_next_s;
            ch_done_r               <= '0;
            transaction_completed_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (state_next_s == ST_GRANT) begin
                        active_channel_r <= AW'(winner_idx_s);
                        grant_beats_r    <= winner_beats_s;
                        beat_cnt_r       <= '0;
                        grant_r          <= winner_onehot_s;
                        grant_valid_r    <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (beat_valid) begin
                        beat_cnt_r <= beat_cnt_r + FW'(1);
                    end
                    if (state_next_s == ST_RELEASE) begin
                        grant_r       <= '0;
                        grant_valid_r <= 1'b0;
                        if (done_hit_s) begin
                            ch_done_r               <= active_onehot_s;
                            transaction_completed_r <= 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    grant_r       <= '0;
                    grant_valid_r <= 1'b0;
                end
                default: begin
                    grant_r       <= '0;
                    grant_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant                 = grant_r;
    assign grant_valid           = grant_valid_r;
    assign active_channel        = active_channel_r;
    assign grant_beats           = grant_beats_r;
    assign ch_done               = ch_done_r;
    assign transaction_completed = transaction_completed_r;

endmodule

// File: tb/tb_channel_grant_sequencer.sv
// Directed bench for channel_grant_sequencer (4 channels, 256-beat frames).
module tb_channel_grant_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ch_start [4];
    logic [31:0] ch_size  [4];
    logic        beat_valid = 1'b0;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [2:0]  active_channel;
    logic [8:0]  grant_beats;
    logic [3:0]  ch_done;
    logic        transaction_completed;

    int tests_run    = 0;
    int tests_failed = 0;

    channel_grant_sequencer #(
        .C_NUM_CHANNELS(4),
        .C_TRANSACTION_SIZE_WIDTH(32),
        .C_FRAME_SIZE(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ch_start(ch_start),
        .ch_size(ch_size),
        .beat_valid(beat_valid),
        .grant(grant),
        .grant_valid(grant_valid),
        .active_channel(active_channel),
        .grant_beats(grant_beats),
        .ch_done(ch_done),
        .transaction_completed(transaction_completed)
    );

    always #5 clk = ~clk;

    // Continuous check: grant is one-hot at most, and zero while not valid.
    always @(negedge clk) begin
        if (!rst) begin
            tests_run++;
            if (($countones(grant) > 1) || (!grant_valid && (grant !== 4'b0000))) begin
                tests_failed++;
                $display("FAIL grant_onehot: grant=%b grant_valid=%b, required one-hot and zero when invalid",
                         grant, grant_valid);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_starts();
        for (int i = 0; i < 4; i++) begin
            ch_start[i] = 1'b0;
            ch_size[i]  = 32'd0;
        end
    endtask

    // Wait (bounded) for grant_valid; reports cycles waited.
    task automatic wait_grant(output int waited, output bit timeout);
        waited  = 0;
        timeout = 1'b0;
        while (grant_valid !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (grant_valid !== 1'b1) timeout = 1'b1;
    endtask

    // Wait for a grant, move all its beats, and capture the release-cycle outputs.
    task automatic run_grant(output logic [3:0] g, output int gb, output logic [3:0] done,
                             output logic tc, output int waited, output bit timeout);
        g = 4'b0000; gb = 0; done = 4'b0000; tc = 1'b0;
        wait_grant(waited, timeout);
        if (!timeout) begin
            g  = grant;
            gb = int'(grant_beats);
            beat_valid = 1'b1;
            repeat (gb) tick();
            beat_valid = 1'b0;
            done = ch_done;
            tc   = transaction_completed;
        end
    endtask

    task automatic test_reset();
        int highs;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests_run++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_beats !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_grant: grant=%b valid=%b beats=%0d, required 0000/0/0", grant, grant_valid, grant_beats);
        end
        tests_run++;
        if (ch_done !== 4'b0000 || transaction_completed !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done: ch_done=%b tc=%b, required 0000/0", ch_done, transaction_completed);
        end
        tests_run++;
        if (active_channel !== 3'd3) begin
            tests_failed++;
            $display("FAIL reset_active: got %0d expected 3", active_channel);
        end
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (grant_valid !== 1'b0) highs++;
        end
        tests_run++;
        if (highs != 0) begin
            tests_failed++;
            $display("FAIL reset_idle: grant_valid high %0d cycles, expected 0", highs);
        end
    endtask

    task automatic test_single();
        ch_start[2] = 1'b1;
        ch_size[2]  = 32'd10;
        tick();
        clear_starts();
        tests_run++;
        if (grant_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_latency_t1: grant_valid=%b expected 0", grant_valid);
        end
        tick();
        tests_run++;
        if (grant_valid !== 1'b1 || grant !== 4'b0100 || grant_beats !== 9'd10 || active_channel !== 3'd2) begin
            tests_failed++;
            $display("FAIL single_grant: valid=%b grant=%b beats=%0d active=%0d, expected 1/0100/10/2",
                     grant_valid, grant, grant_beats, active_channel);
        end
        beat_valid = 1'b1;
        repeat (10) tick();
        beat_valid = 1'b0;
        tests_run++;
        if (grant_valid !== 1'b0 || ch_done !== 4'b0100 || transaction_completed !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_release: valid=%b ch_done=%b tc=%b, expected 0/0100/1",
                     grant_valid, ch_done, transaction_completed);
        end
        tick();
        tests_run++;
        if (ch_done !== 4'b0000 || transaction_completed !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pulse_width: ch_done=%b tc=%b, expected 0000/0", ch_done, transaction_completed);
        end
        tick();
        tests_run++;
        if (grant_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: grant_valid=%b expected 0", grant_valid);
        end
    endtask

    task automatic test_interleave();
        logic [3:0] exp_g    [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0001};
        int         exp_b    [4] = '{256, 100, 256, 88};
        logic [3:0] exp_d    [4] = '{4'b0000, 4'b0010, 4'b0000, 4'b0001};
        int         exp_w    [4] = '{1, 2, 2, 2};
        logic [3:0] g, d;
        logic       tc;
        int         gb, w;
        bit         to;
        ch_start[0] = 1'b1; ch_size[0] = 32'd600;
        ch_start[1] = 1'b1; ch_size[1] = 32'd100;
        tick();
        clear_starts();
        for (int k = 0; k < 4; k++) begin
            run_grant(g, gb, d, tc, w, to);
            tests_run++;
            if (to || g !== exp_g[k] || gb != exp_b[k]) begin
                tests_failed++;
                $display("FAIL interleave_grant[%0d]: timeout=%0d grant=%b beats=%0d, expected %b/%0d",
                         k, to, g, gb, exp_g[k], exp_b[k]);
            end
            tests_run++;
            if (d !== exp_d[k] || tc !== (exp_d[k] != 4'b0000)) begin
                tests_failed++;
                $display("FAIL interleave_done[%0d]: ch_done=%b tc=%b, expected %b", k, d, tc, exp_d[k]);
            end
            tests_run++;
            if (w != exp_w[k]) begin
                tests_failed++;
                $display("FAIL interleave_gap[%0d]: waited %0d cycles, expected %0d", k, w, exp_w[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b1000, 4'b0010, 4'b0100, 4'b0001, 4'b0010};
        logic [3:0] g, d;
        logic       tc;
        int         gb, w;
        bit         to;
        // Channel 3 alone, then 1 and 2 arrive while 3 is being granted.
        ch_start[3] = 1'b1; ch_size[3] = 32'd2;
        tick();
        clear_starts();
        ch_start[1] = 1'b1; ch_size[1] = 32'd3;
        ch_start[2] = 1'b1; ch_size[2] = 32'd3;
        tick();
        clear_starts();
        for (int k = 0; k < 3; k++) begin
            run_grant(g, gb, d, tc, w, to);
            tests_run++;
            if (to || g !== exp_g[k] || d !== exp_g[k]) begin
                tests_failed++;
                $display("FAIL rr_wrap[%0d]: timeout=%0d grant=%b ch_done=%b, expected %b", k, to, g, d, exp_g[k]);
            end
        end
        // Make channel 1 the last served, then 0 and 1 pending together.
        tick();
        ch_start[1] = 1'b1; ch_size[1] = 32'd2;
        tick();
        clear_starts();
        run_grant(g, gb, d, tc, w, to);
        tick();
        ch_start[0] = 1'b1; ch_size[0] = 32'd4;
        ch_start[1] = 1'b1; ch_size[1] = 32'd4;
        tick();
        clear_starts();
        tests_run++;
        if (active_channel !== 3'd1) begin
            tests_failed++;
            $display("FAIL rr_last_active: got %0d expected 1", active_channel);
        end
        for (int k = 3; k < 5; k++) begin
            run_grant(g, gb, d, tc, w, to);
            tests_run++;
            if (to || g !== exp_g[k] || gb != 4) begin
                tests_failed++;
                $display("FAIL rr_from_one[%0d]: timeout=%0d grant=%b beats=%0d, expected %b/4", k, to, g, gb, exp_g[k]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_grant();
        logic [3:0] g, d;
        logic       tc;
        int         gb, w, bad;
        bit         to;
        tick();
        ch_start[0] = 1'b1; ch_size[0] = 32'd20;
        tick();
        clear_starts();
        wait_grant(w, to);
        tests_run++;
        if (to || grant !== 4'b0001 || grant_beats !== 9'd20) begin
            tests_failed++;
            $display("FAIL midrst_grant: timeout=%0d grant=%b beats=%0d, expected 0001/20", to, grant, grant_beats);
        end
        beat_valid = 1'b1;
        repeat (5) tick();
        beat_valid = 1'b0;
        rst = 1'b1;
        tick();
        tests_run++;
        if (grant_valid !== 1'b0 || grant !== 4'b0000 || ch_done !== 4'b0000 || active_channel !== 3'd3) begin
            tests_failed++;
            $display("FAIL midrst_clear: valid=%b grant=%b ch_done=%b active=%0d, expected 0/0000/0000/3",
                     grant_valid, grant, ch_done, active_channel);
        end
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (grant_valid !== 1'b0 || ch_done !== 4'b0000) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL midrst_discard: %0d cycles with grant or ch_done, expected 0", bad);
        end
        ch_start[0] = 1'b1; ch_size[0] = 32'd3;
        tick();
        clear_starts();
        run_grant(g, gb, d, tc, w, to);
        tests_run++;
        if (to || g !== 4'b0001 || gb != 3 || d !== 4'b0001 || tc !== 1'b1 || w != 1) begin
            tests_failed++;
            $display("FAIL midrst_restart: timeout=%0d grant=%b beats=%0d done=%b tc=%b wait=%0d, expected 0001/3/0001/1/1",
                     to, g, gb, d, tc, w);
        end
        tick();
    endtask

    task automatic test_ignored_starts();
        int highs, w;
        bit to;
        ch_start[1] = 1'b1; ch_size[1] = 32'd0;
        tick();
        clear_starts();
        highs = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (grant_valid !== 1'b0) highs++;
        end
        tests_run++;
        if (highs != 0) begin
            tests_failed++;
            $display("FAIL ignore_zero_size: grant_valid high %0d cycles, expected 0", highs);
        end
        ch_start[1] = 1'b1; ch_size[1] = 32'd8;
        tick();
        clear_starts();
        wait_grant(w, to);
        tests_run++;
        if (to || grant !== 4'b0010 || grant_beats !== 9'd8) begin
            tests_failed++;
            $display("FAIL ignore_grant: timeout=%0d grant=%b beats=%0d, expected 0010/8", to, grant, grant_beats);
        end
        beat_valid  = 1'b1;
        ch_start[1] = 1'b1; ch_size[1] = 32'd50;
        tick();
        clear_starts();
        repeat (7) tick();
        beat_valid = 1'b0;
        tests_run++;
        if (grant_valid !== 1'b0 || ch_done !== 4'b0010 || transaction_completed !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_complete: valid=%b ch_done=%b tc=%b, expected 0/0010/1",
                     grant_valid, ch_done, transaction_completed);
        end
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (grant_valid !== 1'b0) highs++;
        end
        tests_run++;
        if (highs != 0) begin
            tests_failed++;
            $display("FAIL ignore_restart: grant_valid high %0d cycles, expected 0", highs);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] g, d;
        logic       tc;
        int         gb, w;
        bit         to;
        ch_start[2] = 1'b1; ch_size[2] = 32'd300;
        tick();
        clear_starts();
        run_grant(g, gb, d, tc, w, to);
        tests_run++;
        if (to || g !== 4'b0100 || gb != 256 || d !== 4'b0000 || w != 1) begin
            tests_failed++;
            $display("FAIL b2b_first: timeout=%0d grant=%b beats=%0d done=%b wait=%0d, expected 0100/256/0000/1",
                     to, g, gb, d, w);
        end
        run_grant(g, gb, d, tc, w, to);
        tests_run++;
        if (to || g !== 4'b0100 || gb != 44 || d !== 4'b0100 || tc !== 1'b1 || w != 2) begin
            tests_failed++;
            $display("FAIL b2b_residue: timeout=%0d grant=%b beats=%0d done=%b tc=%b wait=%0d, expected 0100/44/0100/1/2",
                     to, g, gb, d, tc, w);
        end
        tick();
    endtask

    initial begin
        clear_starts();
        test_reset();
        test_single();
        test_interleave();
        test_round_robin();
        test_reset_mid_grant();
        test_ignored_starts();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/channel_grant_sequencer.md
CHANNEL_GRANT_SEQUENCER -- requirements
Module: channel_grant_sequencer

Interface
REQ-001 SHALL have parameter C_NUM_CHANNELS, default 4: number of DMA channels; range 2..32.
REQ-002 SHALL have parameter C_TRANSACTION_SIZE_WIDTH, default 32: width of per-channel transfer size in beats.
REQ-003 SHALL have parameter C_FRAME_SIZE, default 256: max beats per grant; power of two, at least 2.
REQ-004 SHALL use a single clock and a synchronous, active-high reset: clk in, 1, rising-edge clock; rst in, 1, synchronous active-high reset.
REQ-005 SHALL have the following data ports:
- ch_start  in  [C_NUM_CHANNELS] array of 1: per-channel transfer request pulse.
- ch_size  in  [C_NUM_CHANNELS] array of C_TRANSACTION_SIZE_WIDTH: beats to transfer, sampled with ch_start.
- beat_valid  in  1: one beat of the granted channel moved this cycle.
- grant  out  C_NUM_CHANNELS: one-hot grant.
- grant_valid  out  1: grant is live.
- active_channel  out  LOG2(C_NUM_CHANNELS)+1: index of last or current granted channel.
- grant_beats  out  LOG2(C_FRAME_SIZE)+1: beats allotted to the live grant.
- ch_done  out  C_NUM_CHANNELS: per-channel one-cycle completion pulse.
- transaction_completed  out  1: one-cycle pulse, OR of ch_done.

Function
REQ-006 SHALL keep a registered remaining[i] counter (C_TRANSACTION_SIZE_WIDTH bits) per channel; channel i is pending iff remaining[i] != 0.
REQ-007 SHALL load remaining[i] = ch_size[i] on ch_start[i] only if all of these hold: remaining[i] == 0, ch_size[i] != 0, and channel i is not the owner in GRANT/RELEASE. Otherwise the start SHALL be ignored.
REQ-008 SHALL implement FSM states IDLE, GRANT, RELEASE.
REQ-009 IDLE: if any channel is pending, the FSM SHALL go to GRANT on the next edge. The winner is the first pending channel searched from (active_channel+1) mod C_NUM_CHANNELS upward, wrapping; active_channel SHALL take the winner index. If no channel is pending, the FSM SHALL stay in IDLE.
REQ-010 On entering GRANT, the block SHALL register grant_beats = min(remaining[winner], C_FRAME_SIZE) and clear beat_cnt.
REQ-011 GRANT: grant_valid = 1 and grant = one-hot of active_channel. Each beat_valid SHALL increment beat_cnt. beat_valid with beat_cnt == grant_beats-1 SHALL move the FSM to RELEASE.
REQ-012 RELEASE (exactly one cycle): grant_valid = 0 and grant = 0; remaining[active] -= grant_beats; the FSM then goes to IDLE.
REQ-013 In the RELEASE cycle, if remaining[active] == grant_beats, the block SHALL assert ch_done[active] and transaction_completed for that cycle only.
REQ-014 beat_valid outside GRANT SHALL be ignored; no counter changes.
REQ-015 Latency: ch_start high in cycle t with the FSM idle and no other channel pending SHALL give grant_valid high in cycle t+2.
REQ-016 Gap between consecutive grants SHALL be exactly 2 cycles (RELEASE, IDLE), including back-to-back grants to the same channel.
REQ-017 A channel larger than C_FRAME_SIZE SHALL be served in frame-sized slices, interleaved round-robin with other pending channels. The final slice SHALL be the residue.
REQ-018 Starts to non-owner channels SHALL be accepted in any state, including same-cycle starts on several channels.
REQ-019 grant SHALL never have more than one bit set. grant SHALL be zero whenever grant_valid is 0.

Reset
REQ-020 rst SHALL take effect on the next clock edge, with priority over all other inputs, and SHALL set:
- state = IDLE; all remaining = 0; beat_cnt = 0
- grant = 0, grant_valid = 0, grant_beats = 0
- ch_done = 0, transaction_completed = 0
- active_channel = C_NUM_CHANNELS-1, so the first search starts at channel 0
REQ-021 rst mid-grant SHALL abandon the grant and discard all pending work, with no ch_done pulse.

Verification
REQ-022 Assert rst for 2 cycles, then release -> all outputs zero, active_channel = 3, no grant for 10 idle cycles.
REQ-023 ch_start[2] with ch_size 10 -> 2 cycles later grant = 4'b0100, grant_beats = 10. After 10 beat_valid: RELEASE, ch_done = 4'b0100 and transaction_completed pulse for 1 cycle, then IDLE.
REQ-024 Same-cycle starts ch0 = 600 and ch1 = 100 -> grant sequence ch0/256, ch1/100 (ch_done[1]), ch0/256, ch0/88 (ch_done[0]), with 2-cycle gaps.
REQ-025 Round-robin wrap: after channel 3 is served, channels 1 and 2 pending -> channel 1 is granted before channel 2. With active_channel = 1 and channels 0 and 1 pending -> channel 0 is granted.
REQ-026 ch_start[0] with size 20, then rst after 5 beats -> next cycle grant_valid = 0, remaining[0] = 0, no ch_done. A new start with size 3 is then served normally.
REQ-027 ch_start[1] with size 0, and a re-start of pending channel 1 with size 50 while its 8-beat transfer is live -> both ignored; only the 8-beat transfer completes.
